// File: rtl/serial_bridge_pkg.sv
// Shared types and constants for the UART-to-memory command bridge.
// Holds the state encoding, the response bytes and the default opcodes.
package serial_bridge_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_AH,
    S_AL,
    S_DH,
    S_DL,
    S_MEM,
    S_TX,
    S_TX_LO,
    S_TX_HI
  } state_t;

  localparam logic [7:0] RSP_ACK       = 8'h06;
  localparam logic [7:0] RSP_NAK       = 8'h15;
  localparam logic [7:0] DEF_CMD_WRITE = 8'h57;
  localparam logic [7:0] DEF_CMD_READ  = 8'h52;

endpackage

// File: rtl/serial_resp_sender.sv
// Response transmitter: sends up to two buffered bytes, one per driver
// ready handshake (ready high -> en pulse -> ready low -> ready high).
module serial_resp_sender
  import serial_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data,
  input  logic [1:0]  count,
  output logic        done,
  input  logic        ser_out_rdy,
  output logic [7:0]  ser_data_out,
  output logic        ser_out_en
);

  state_t      state_q;
  logic [15:0] rsp_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rsp_q        <= '0;
      cnt_q        <= '0;
      done         <= 1'b0;
      ser_data_out <= '0;
      ser_out_en   <= 1'b0;
    end else begin
      done       <= 1'b0;
      ser_out_en <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rsp_q   <= data;
            cnt_q   <= count;
            state_q <= S_TX;
          end
        end
        S_TX: begin
          if (ser_out_rdy) begin
            ser_data_out <= rsp_q[15:8];
            ser_out_en   <= 1'b1;
            state_q      <= S_TX_LO;
          end
        end
        S_TX_LO: begin
          if (!ser_out_rdy) state_q <= S_TX_HI;
        end
        S_TX_HI: begin
          if (ser_out_rdy) begin
            cnt_q <= cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
              done    <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              rsp_q   <= {rsp_q[7:0], 8'h00};
              state_q <= S_TX;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial_mem_bridge.sv
// Command responder on the UART byte interface: parses read/write frames,
// performs one 16-bit memory access and returns ACK/NAK or read data.
module serial_mem_bridge
  import serial_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLK = 65535,
  parameter logic [7:0]  CMD_WRITE   = DEF_CMD_WRITE,
  parameter logic [7:0]  CMD_READ    = DEF_CMD_READ
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ser_data_in,
  input  logic        ser_in_cplt,
  input  logic        ser_in_error,
  output logic [7:0]  ser_data_out,
  output logic        ser_out_en,
  input  logic        ser_out_rdy,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        frame_err
);

  localparam int unsigned   TW       = $clog2(TIMEOUT_CLK + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLK - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  state_t        state_q;
  logic          is_write_q;
  logic [TW-1:0] tmo_q;
  logic          tx_start_q;
  logic [15:0]   tx_data_q;
  logic [1:0]    tx_count_q;
  logic          tx_done;
  logic          rx_state;
  logic          opcode_ok;
  logic          nak;

  assign rx_state  = state_q inside {S_IDLE, S_AH, S_AL, S_DH, S_DL};
  assign opcode_ok = (ser_data_in == CMD_WRITE) || (ser_data_in == CMD_READ);
  // Line errors win over a coincident byte; an unknown opcode is NAKed too.
  assign nak = rx_state &&
               (ser_in_error || (state_q == S_IDLE && ser_in_cplt && !opcode_ok));
  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      tmo_q      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      frame_err  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      tx_count_q <= '0;
    end else begin
      frame_err  <= 1'b0;
      tx_start_q <= 1'b0;
      if (nak) begin
        frame_err  <= 1'b1;
        tmo_q      <= '0;
        tx_start_q <= 1'b1;
        tx_data_q  <= {RSP_NAK, 8'h00};
        tx_count_q <= 2'd1;
        state_q    <= S_TX;
      end else begin
        case (state_q)
          S_IDLE: begin
            tmo_q <= '0;
            if (ser_in_cplt) begin
              is_write_q <= (ser_data_in == CMD_WRITE);
              state_q    <= S_AH;
            end
          end
          S_AH, S_AL, S_DH, S_DL: begin
            if (ser_in_cplt) begin
              tmo_q <= '0;
              case (state_q)
                S_AH: begin
                  mem_addr[15:8] <= ser_data_in;
                  state_q        <= S_AL;
                end
                S_AL: begin
                  mem_addr[7:0] <= ser_data_in;
                  state_q       <= is_write_q ? S_DH : S_MEM;
                end
                S_DH: begin
                  mem_wdata[15:8] <= ser_data_in;
                  state_q         <= S_DL;
                end
                default: begin
                  mem_wdata[7:0] <= ser_data_in;
                  state_q        <= S_MEM;
                end
              endcase
            end else if (tmo_q == TMO_LAST) begin
              // Stalled partial frame: drop it without answering.
              frame_err <= 1'b1;
              tmo_q     <= '0;
              state_q   <= S_IDLE;
            end else begin
              tmo_q <= tmo_q + TMO_ONE;
            end
          end
          S_MEM: begin
            if (!mem_we && !mem_re) begin
              mem_we <= is_write_q;
              mem_re <= !is_write_q;
            end else if (mem_ack) begin
              mem_we     <= 1'b0;
              mem_re     <= 1'b0;
              tx_start_q <= 1'b1;
              tx_data_q  <= is_write_q ? {RSP_ACK, 8'h00} : mem_rdata;
              tx_count_q <= is_write_q ? 2'd1 : 2'd2;
              state_q    <= S_TX;
            end
          end
          S_TX: begin
            if (tx_done) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  serial_resp_sender u_sender (
    .clk          (clk),
    .rst          (rst),
    .start        (tx_start_q),
    .data         (tx_data_q),
    .count        (tx_count_q),
    .done         (tx_done),
    .ser_out_rdy  (ser_out_rdy),
    .ser_data_out (ser_data_out),
    .ser_out_en   (ser_out_en)
  );

endmodule

// File: tb/tb_serial_mem_bridge.sv
// Bench for serial_mem_bridge: frame-level model of expected transmit bytes and
// memory requests, with host and memory emulators and directed frames.
module tb_serial_mem_bridge;

  localparam int unsigned Tmo    = 100;
  localparam int unsigned TxBusy = 4;
  localparam int unsigned MemLat = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ser_data_in;
  logic        ser_in_cplt;
  logic        ser_in_error;
  logic [7:0]  ser_data_out;
  logic        ser_out_en;
  logic        ser_out_rdy;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        frame_err;

  serial_mem_bridge #(
    .TIMEOUT_CLK (Tmo),
    .CMD_WRITE   (8'h57),
    .CMD_READ    (8'h52)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ser_data_in  (ser_data_in),
    .ser_in_cplt  (ser_in_cplt),
    .ser_in_error (ser_in_error),
    .ser_data_out (ser_data_out),
    .ser_out_en   (ser_out_en),
    .ser_out_rdy  (ser_out_rdy),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  exp_tx[$];
  logic [32:0] exp_ops[$];  // {is_write, addr, wdata}
  logic [7:0]  tx_log[$];
  logic [15:0] model_mem[logic [15:0]];
  logic [15:0] resp_mem[logic [15:0]];
  int          ferr_exp  = 0;
  int          ferr_seen = 0;
  int          req_seen  = 0;
  logic        host_block = 1'b0;
  logic        mem_hold   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0d, required none or within bound", name, act);
  endtask

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    return model_mem.exists(a) ? model_mem[a] : ~a;
  endfunction

  // Host-side driver emulation: after each en it goes busy for a few cycles.
  initial begin : host
    ser_out_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && ser_out_en) begin
        @(posedge clk);
        #1 ser_out_rdy = 1'b0;
        repeat (TxBusy) @(posedge clk);
        #1 ser_out_rdy = 1'b1;
      end else begin
        #1 ser_out_rdy = !host_block;
      end
    end
  end

  // Memory emulation: acks each request MemLat cycles after it appears.
  initial begin : mem_resp
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && !mem_hold && (mem_we || mem_re)) begin
        repeat (MemLat) @(posedge clk);
        #1;
        if (mem_we) resp_mem[mem_addr] = mem_wdata;
        mem_rdata = resp_mem.exists(mem_addr) ? resp_mem[mem_addr] : ~mem_addr;
        mem_ack   = 1'b1;
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  // Per-cycle comparison against the frame-level model.
  initial begin : compare_proc
    logic        en_prev, req_prev, ack_prev, ferr_prev, holding;
    logic [7:0]  held, eb;
    logic [32:0] op;
    en_prev = 0; req_prev = 0; ack_prev = 0; ferr_prev = 0; holding = 0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_prev = 0; req_prev = 0; ack_prev = 0; ferr_prev = 0; holding = 0;
      end else begin
        if (ser_out_en) begin
          check("en_single", {31'd0, en_prev}, 32'd0);
          check("en_rdy", {31'd0, ser_out_rdy}, 32'd1);
          if (exp_tx.size() == 0) flag("tx_unexpected", int'(ser_data_out));
          else begin
            eb = exp_tx.pop_front();
            check("tx_byte", {24'd0, ser_data_out}, {24'd0, eb});
          end
          tx_log.push_back(ser_data_out);
          held    = ser_data_out;
          holding = 1;
        end else if (holding) begin
          if (ser_out_rdy) holding = 0;
          else check("tx_hold", {24'd0, ser_data_out}, {24'd0, held});
        end
        if ((mem_we || mem_re) && !req_prev) begin
          check("req_excl", {31'd0, mem_we & mem_re}, 32'd0);
          if (exp_ops.size() == 0) flag("req_unexpected", int'(mem_addr));
          else begin
            op = exp_ops.pop_front();
            check("req_kind", {31'd0, mem_we}, {31'd0, op[32]});
            check("req_addr", {16'd0, mem_addr}, {16'd0, op[31:16]});
            if (op[32]) check("req_wdata", {16'd0, mem_wdata}, {16'd0, op[15:0]});
          end
          req_seen++;
        end
        if (req_prev && !ack_prev) check("req_held", {31'd0, mem_we | mem_re}, 32'd1);
        if (req_prev && ack_prev) check("req_drop", {31'd0, mem_we | mem_re}, 32'd0);
        if (frame_err) begin
          ferr_seen++;
          check("ferr_single", {31'd0, ferr_prev}, 32'd0);
        end
        en_prev   = ser_out_en;
        req_prev  = mem_we | mem_re;
        ack_prev  = mem_ack;
        ferr_prev = frame_err;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic err);
    @(posedge clk);
    #1;
    ser_data_in  = b;
    ser_in_cplt  = !err;
    ser_in_error = err;
    @(posedge clk);
    #1;
    ser_in_cplt  = 1'b0;
    ser_in_error = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wr_frame(input logic [15:0] a, input logic [15:0] d);
    exp_ops.push_back({1'b1, a, d});
    exp_tx.push_back(8'h06);
    model_mem[a] = d;
    send_byte(8'h57, 1'b0);
    send_byte(a[15:8], 1'b0);
    send_byte(a[7:0], 1'b0);
    send_byte(d[15:8], 1'b0);
    send_byte(d[7:0], 1'b0);
  endtask

  task automatic rd_frame(input logic [15:0] a);
    logic [15:0] v;
    v = model_rd(a);
    exp_ops.push_back({1'b0, a, 16'h0000});
    exp_tx.push_back(v[15:8]);
    exp_tx.push_back(v[7:0]);
    send_byte(8'h52, 1'b0);
    send_byte(a[15:8], 1'b0);
    send_byte(a[7:0], 1'b0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_tx.size() != 0 || !ser_out_rdy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) flag({name, "_idle_timeout"}, n);
    check({name, "_ops_left"}, exp_ops.size(), 32'd0);
    check({name, "_ferr_count"}, ferr_seen, ferr_exp);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish within bound");
    $fatal(1);
  end

  initial begin : stim
    int base, reqs, n;
    rst = 1'b1; ser_data_in = '0; ser_in_cplt = 1'b0; ser_in_error = 1'b0;
    resp_mem[16'h0010]  = 16'hBEEF;
    model_mem[16'h0010] = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", {31'd0, ser_out_en}, 32'd0);
    check("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, 32'd0);
    check("rst_data_out", {24'd0, ser_data_out}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Write 57 12 34 AB CD -> ACK
    base = tx_log.size(); reqs = req_seen;
    wr_frame(16'h1234, 16'hABCD);
    wait_idle("wr");
    check("wr_tx_count", tx_log.size() - base, 32'd1);
    if (tx_log.size() > base) check("wr_ack_byte", {24'd0, tx_log[base]}, 32'h06);
    check("wr_addr", {16'd0, mem_addr}, 32'h1234);
    check("wr_wdata", {16'd0, mem_wdata}, 32'hABCD);
    check("wr_reqs", req_seen - reqs, 32'd1);

    // Read 52 00 10 -> BE EF
    base = tx_log.size();
    rd_frame(16'h0010);
    wait_idle("rd");
    check("rd_tx_count", tx_log.size() - base, 32'd2);
    if (tx_log.size() > base + 1)
      check("rd_bytes", {16'd0, tx_log[base], tx_log[base+1]}, 32'hBEEF);

    // Bad opcode 41 with the driver busy: NAK waits for ready
    base = tx_log.size(); reqs = req_seen;
    host_block = 1'b1;
    ferr_exp++;
    exp_tx.push_back(8'h15);
    send_byte(8'h41, 1'b0);
    repeat (10) @(negedge clk);
    check("nak_busy_held", {31'd0, busy}, 32'd1);
    check("nak_gated", tx_log.size() - base, 32'd0);
    host_block = 1'b0;
    wait_idle("badop");
    check("badop_tx_count", tx_log.size() - base, 32'd1);
    if (tx_log.size() > base) check("badop_nak", {24'd0, tx_log[base]}, 32'h15);
    check("badop_no_req", req_seen - reqs, 32'd0);

    // Line error on third byte of a write, then a normal read
    base = tx_log.size(); reqs = req_seen;
    ferr_exp++;
    exp_tx.push_back(8'h15);
    send_byte(8'h57, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    wait_idle("err");
    check("err_no_req", req_seen - reqs, 32'd0);
    if (tx_log.size() > base) check("err_nak", {24'd0, tx_log[base]}, 32'h15);
    base = tx_log.size();
    rd_frame(16'h0000);
    wait_idle("rd0");
    if (tx_log.size() > base + 1)
      check("rd0_bytes", {16'd0, tx_log[base], tx_log[base+1]}, 32'hFFFF);
    base = tx_log.size();
    rd_frame(16'h1234);
    wait_idle("rdback");
    if (tx_log.size() > base + 1)
      check("rdback_bytes", {16'd0, tx_log[base], tx_log[base+1]}, 32'hABCD);

    // Inter-byte timeout: 57 12 then stall
    base = tx_log.size(); reqs = req_seen;
    ferr_exp++;
    send_byte(8'h57, 1'b0);
    @(posedge clk);
    #1;
    ser_data_in = 8'h12;
    ser_in_cplt = 1'b1;
    @(posedge clk);
    #1 ser_in_cplt = 1'b0;
    n = 0;
    while (!frame_err && n < 3 * Tmo) begin
      @(negedge clk);
      n++;
      if (n == Tmo) check("tmo_busy_before", {31'd0, busy}, 32'd1);
    end
    check("tmo_cycles", n, Tmo + 1);
    check("tmo_busy_after", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    check("tmo_no_tx", tx_log.size() - base, 32'd0);
    check("tmo_no_req", req_seen - reqs, 32'd0);
    check("tmo_ferr_count", ferr_seen, ferr_exp);

    // Reset while a read request is outstanding
    mem_hold = 1'b1;
    rd_frame(16'h0010);
    n = 0;
    while (!mem_re && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rstmem_re_seen", {31'd0, mem_re}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmem_re_drop", {31'd0, mem_re}, 32'd0);
    check("rstmem_busy_drop", {31'd0, busy}, 32'd0);
    check("rstmem_en_low", {31'd0, ser_out_en}, 32'd0);
    check("rstmem_addr", {16'd0, mem_addr}, 32'd0);
    exp_tx.delete();
    exp_ops.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mem_hold = 1'b0;
    check("rstmem_idle", {31'd0, busy}, 32'd0);
    wr_frame(16'h00A5, 16'h5A5A);
    wait_idle("post_rst_wr");
    base = tx_log.size();
    rd_frame(16'h00A5);
    wait_idle("post_rst_rd");
    if (tx_log.size() > base + 1)
      check("post_rst_bytes", {16'd0, tx_log[base], tx_log[base+1]}, 32'h5A5A);
    else flag("post_rst_tx_count", tx_log.size() - base);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_mem_bridge.md
Name: serial_mem_bridge

Overview:
- Host-side command responder that sits on the user side of the UART serial driver byte interface.
- Parses fixed-length command frames (read or write of one 16-bit word), issues a single request on a simple memory port, and returns the response bytes through the driver's transmit handshake.
- Gives a PC host debug and load access to on-chip memory over the existing UART link.

Parameters:
- TIMEOUT_CLK, 65535, clocks allowed between consecutive bytes of one frame before the partial frame is discarded.
- CMD_WRITE, 8'h57, opcode for a write frame.
- CMD_READ, 8'h52, opcode for a read frame.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ser_data_in  in  8  received byte from the serial driver
- ser_in_cplt  in  1  1-cycle pulse: ser_data_in is valid
- ser_in_error  in  1  1-cycle pulse: byte received with framing or parity error
- ser_data_out  out  8  byte to transmit
- ser_out_en  out  1  1-cycle transmit request
- ser_out_rdy  in  1  driver idle and able to accept a byte
- mem_addr  out  16  memory address
- mem_wdata  out  16  write data
- mem_we  out  1  write request, held until mem_ack
- mem_re  out  1  read request, held until mem_ack
- mem_ack  in  1  request complete; mem_rdata is valid in the same cycle
- mem_rdata  in  16  read data
- busy  out  1  high in every state except S_IDLE
- frame_err  out  1  1-cycle pulse on a bad opcode, an ser_in_error, or an inter-byte timeout

Behaviour:
- Reset values: all outputs 0, state S_IDLE, timeout counter 0, response buffer 0.
- Frame formats, big-endian:
  - write: 57 AH AL DH DL
  - read: 52 AH AL
- Responses:
  - write: 06 (ACK)
  - read: DH DL
  - bad opcode or ser_in_error: 15 (NAK)
  - timeout: no response
- States: S_IDLE, S_AH, S_AL, S_DH, S_DL, S_MEM, S_TX, S_TX_LO, S_TX_HI.
- S_IDLE on ser_in_cplt:
  - byte == CMD_WRITE or CMD_READ: latch the opcode, go to S_AH.
  - any other byte: pulse frame_err, load NAK (count 1), go to S_TX.
- S_AH then S_AL: latch the address bytes.
- After S_AL:
  - write: go to S_DH, then S_DL, latching the data bytes.
  - read: go to S_MEM.
  - After S_DL: go to S_MEM.
- ser_in_error in any receive state (S_IDLE..S_DL): pulse frame_err, discard the frame, load NAK, go to S_TX.
- Timeout counter:
  - Cleared on every ser_in_cplt and in S_IDLE; increments in S_AH..S_DL.
  - On reaching TIMEOUT_CLK: pulse frame_err, go to S_IDLE, send nothing.
- S_MEM:
  - mem_we or mem_re is asserted on the cycle after entry and held until mem_ack is sampled high, then cleared.
  - Write: load ACK, count 1.
  - Read: load {mem_rdata[15:8], mem_rdata[7:0]}, count 2.
  - Go to S_TX. mem_ack arriving outside S_MEM is ignored.
- Transmit handshake, per byte:
  - S_TX: when ser_out_rdy == 1, drive ser_data_out = buffer head and pulse ser_out_en for exactly one cycle; go to S_TX_LO.
  - S_TX_LO: wait for ser_out_rdy == 0.
  - S_TX_HI: wait for ser_out_rdy == 1.
  - Then decrement the count. If nonzero, shift the buffer and return to S_TX; else go to S_IDLE.
  - ser_data_out is held stable from the ser_out_en cycle through S_TX_HI.
- Bytes received in S_MEM or S_TX*: dropped silently, no frame_err.
- Back-to-back frames: a new opcode is accepted the first cycle in S_IDLE; a ser_in_cplt coincident with the return to S_IDLE is dropped.
- Simultaneous ser_in_cplt and ser_in_error: the error takes priority.
- Reset mid-operation: everything aborts immediately and mem_we, mem_re, and ser_out_en drop asynchronously. A byte already handed to the driver still completes on the line; that is the driver's responsibility.

Decomposition:
- Package serial_bridge_pkg:
  - state enum
  - RSP_ACK = 8'h06
  - RSP_NAK = 8'h15
  - default opcodes
- Sub-module serial_resp_sender: 2-byte buffer plus count, implementing the S_TX/S_TX_LO/S_TX_HI handshake, with a start/done interface to the main FSM.

Test Plan:
- Write frame 57 12 34 AB CD, mem_ack 3 cycles later:
  - mem_addr = 16'h1234, mem_wdata = 16'hABCD, mem_we held exactly until the ack;
  - a single ser_out_en with byte 06.
- Read frame 52 00 10, mem_rdata = 16'hBEEF on the ack:
  - mem_re asserted;
  - transmitted bytes BE then EF, each en a 1-cycle pulse gated by the rdy low-then-high sequence.
- Byte 41 in S_IDLE:
  - frame_err pulse;
  - byte 15 transmitted;
  - no memory request.
- ser_in_error on the third byte of a write:
  - frame_err pulse and NAK 15;
  - mem_we never asserted;
  - a following valid frame 52 00 00 is served normally.
- With TIMEOUT_CLK = 100, send 57 12 then stall 150 cycles:
  - frame_err pulse at count 100;
  - busy falls;
  - no transmit.
- rst asserted during S_MEM with mem_re high:
  - mem_re, busy, and ser_out_en drop asynchronously;
  - after release, the state is S_IDLE and the next frame is served.
